// File: rtl/fetch_sequencer_if.sv
// Instruction-memory byte-read bus between fetch_sequencer (master) and the
// instruction memory (slave).
interface fetch_sequencer_if;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Two-byte instruction fetch / execute sequencer with branch, halt and optional
// retired-instruction counter (enabled by defining FETCH_SEQ_INSTRET_EN).
module fetch_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  fetch_sequencer_if.master   mem,
  input  logic                run_in,
  output logic [15:0]         inst_out,
  output logic                inst_valid,
  input  logic                exec_done,
  input  logic                branch_en,
  input  logic [7:0]          branch_target,
  input  logic                halt_in,
  output logic [7:0]          pc_out,
  output logic [1:0]          state_out,
  output logic [15:0]         instret_out
);

  typedef enum logic [1:0] {
    FETCH_L = 2'd0,
    FETCH_H = 2'd1,
    EXEC    = 2'd2,
    HALT    = 2'd3
  } state_t;

  // Instructions are halfword aligned, so the reset PC is forced even.
  localparam logic [7:0] PC_INIT = {RESET_PC[7:1], 1'b0};

  state_t      state_reg;
  logic [7:0]  pc_reg;
  logic [15:0] inst_reg;
  logic        low_accept;
  logic        high_accept;
  logic        retire;

  assign low_accept  = (state_reg == FETCH_L) && run_in && mem.mem_ack;
  assign high_accept = (state_reg == FETCH_H) && mem.mem_ack;
  assign retire      = (state_reg == EXEC) && exec_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= FETCH_L;
      pc_reg    <= PC_INIT;
      inst_reg  <= 16'h0000;
    end else begin
      case (state_reg)
        FETCH_L: begin
          if (low_accept) begin
            inst_reg[7:0] <= mem.mem_rdata;
            state_reg     <= FETCH_H;
          end
        end
        FETCH_H: begin
          if (high_accept) begin
            inst_reg[15:8] <= mem.mem_rdata;
            state_reg      <= EXEC;
          end
        end
        EXEC: begin
          if (retire) begin
            pc_reg    <= branch_en ? {branch_target[7:1], 1'b0} : pc_reg + 8'd2;
            state_reg <= halt_in ? HALT : FETCH_L;
          end
        end
        default: begin
          state_reg <= HALT;
        end
      endcase
    end
  end

  // The reset term keeps a pending request from being visible while rst is
  // high, even though run_in alone would otherwise assert it in FETCH_L.
  assign mem.mem_req  = !rst && (((state_reg == FETCH_L) && run_in) || (state_reg == FETCH_H));
  assign mem.mem_addr = (state_reg == FETCH_H) ? pc_reg + 8'd1 : pc_reg;

  assign inst_out   = inst_reg;
  assign inst_valid = (state_reg == EXEC);
  assign pc_out     = pc_reg;
  assign state_out  = state_reg;

`ifdef FETCH_SEQ_INSTRET_EN
  logic [15:0] instret_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_reg <= 16'h0000;
    end else if (retire) begin
      instret_reg <= instret_reg + 16'd1;
    end
  end

  assign instret_out = instret_reg;
`else
  assign instret_out = 16'h0000;
`endif

endmodule
